// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues one memory read at a time,
// buffers returned words in a small FIFO and hands them out over valid/ready.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        clr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t             state_reg, state_next;
  logic [31:0]        fetch_pc_reg, fetch_pc_next;
  logic               mem_req_reg, mem_req_next;
  logic [31:0]        mem_addr_reg, mem_addr_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;

  logic [31:0]        fifo_word_reg [FIFO_DEPTH];
  logic [31:0]        fifo_pc_reg   [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] slot_we;

  logic               ack_live;
  logic               do_push;
  logic               do_pop;
  logic               room_after;
  logic [31:0]        pc_inc;
  logic [31:0]        target_aligned;

  // An ack only counts while a request is outstanding in WAIT; a redirect
  // in the same cycle turns it into a discarded stale word.
  assign ack_live       = mem_ack && (state_reg == S_WAIT);
  assign do_push        = ack_live && !branch_valid;
  assign do_pop         = instr_valid && instr_ready;
  assign pc_inc         = fetch_pc_reg + 32'd4;
  assign target_aligned = {branch_target[31:2], 2'b00};

  always_comb begin
    count_next  = count_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (branch_valid) begin
      count_next  = '0;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      count_next = count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
      if (do_push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    end
  end

  assign room_after = (count_next < DEPTH_C);

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    mem_req_next  = mem_req_reg;
    mem_addr_next = mem_addr_reg;
    case (state_reg)
      S_IDLE: begin
        if (branch_valid) begin
          fetch_pc_next = target_aligned;
        end else if (count_reg < DEPTH_C) begin
          mem_req_next  = 1'b1;
          mem_addr_next = fetch_pc_reg;
          state_next    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (branch_valid) begin
          fetch_pc_next = target_aligned;
          mem_req_next  = 1'b0;
          state_next    = mem_ack ? S_IDLE : S_DRAIN;
        end else if (mem_ack) begin
          fetch_pc_next = pc_inc;
          if (room_after) begin
            mem_addr_next = pc_inc;
          end else begin
            mem_req_next = 1'b0;
            state_next   = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        mem_req_next = 1'b0;
        if (branch_valid) fetch_pc_next = target_aligned;
        // The ack retires the abandoned request; its data is dropped.
        if (mem_ack) begin
          if (branch_valid || !room_after) begin
            state_next = S_IDLE;
          end else begin
            mem_req_next  = 1'b1;
            mem_addr_next = fetch_pc_reg;
            state_next    = S_WAIT;
          end
        end
      end
      default: begin
        mem_req_next = 1'b0;
        state_next   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg    <= S_IDLE;
      fetch_pc_reg <= RESET_PC;
      mem_req_reg  <= 1'b0;
      mem_addr_reg <= RESET_PC;
      count_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      mem_req_reg  <= mem_req_next;
      mem_addr_reg <= mem_addr_next;
      count_reg    <= count_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
    end
  end

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot_we
    assign slot_we[gi] = do_push && (wr_ptr_reg == PTR_W'(gi));
  end

  // Payload storage needs no reset: the outputs are gated by instr_valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (slot_we[i]) begin
        fifo_word_reg[i] <= mem_rdata;
        fifo_pc_reg[i]   <= fetch_pc_reg;
      end
    end
  end

  assign instr_valid = (count_reg != '0);
  assign instruction = instr_valid ? fifo_word_reg[rd_ptr_reg] : 32'h0;
  assign instr_pc    = instr_valid ? fifo_pc_reg[rd_ptr_reg]   : 32'h0;
  assign mem_req     = mem_req_reg;
  assign mem_addr    = mem_addr_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: queue-level reference model with a memory
// responder, directed scenarios pinned by literal values, then random traffic.
module tb_instr_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        clr;
  logic        mem_req, mem_ack, branch_valid, instr_valid, instr_ready;
  logic [31:0] mem_addr, mem_rdata, branch_target, instruction, instr_pc;

  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pc;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .clr(clr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .instruction(instruction), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready)
  );

  // Second instance starting at the top of the address space; memory always
  // acks at once and returns the inverted address as data.
  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(DEPTH)) dut_wrap (
    .clk(clk), .clr(clr),
    .mem_req(w_req), .mem_addr(w_addr), .mem_ack(w_req), .mem_rdata(~w_addr),
    .branch_valid(1'b0), .branch_target(32'h0),
    .instruction(w_instr), .instr_pc(w_pc),
    .instr_valid(w_valid), .instr_ready(1'b1)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } beat_t;

  beat_t       q[$];
  beat_t       wrap_log[$];
  logic [31:0] log_pc[$];
  logic [31:0] log_word[$];
  int          log_cyc[$];

  logic [31:0] exp_pc;
  bit          drain_owed;
  bit          req_hold;
  int          idle_run;
  int          cyc;
  int          checks = 0;
  int          passes = 0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    case (a)
      32'h0: return 32'h03B0_1001;
      32'h4: return 32'h03B0_10AA;
      32'h8: return 32'h03B0_A0BA;
      32'hC: return 32'h03B0_A0FF;
      default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    q.delete();
    exp_pc     = 32'h0;
    drain_owed = 1'b0;
    req_hold   = 1'b0;
    idle_run   = 0;
  endtask

  always @(negedge clk) begin
    if (!clr && w_valid && wrap_log.size() < 2) wrap_log.push_back('{pc: w_pc, word: w_instr});
  end

  // One cycle: compare DUT with the model, drive inputs, advance the model.
  task automatic step(input int ackp, input int readyp, input bit br, input logic [31:0] tgt);
    bit   a, r, outstanding;
    beat_t b;
    @(negedge clk);
    cyc++;
    chk("instr_valid", 32'(instr_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("instruction", instruction, q[0].word);
      chk("instr_pc", instr_pc, q[0].pc);
    end
    if (req_hold) chk("req_held", 32'(mem_req), 32'd1);
    if (mem_req) begin
      chk("mem_addr", mem_addr, exp_pc);
      chk("slot_reserved", 32'(q.size() < DEPTH), 32'd1);
      chk("no_req_in_drain", 32'(drain_owed), 32'd0);
    end
    if (!mem_req && !drain_owed && q.size() < DEPTH) idle_run++;
    else idle_run = 0;
    if (idle_run > 0) chk("fetch_stall", 32'(idle_run <= 2), 32'd1);

    outstanding = mem_req || drain_owed;
    if (outstanding) a = ($urandom_range(99) < ackp);
    else a = (ackp > 0 && ackp < 100 && $urandom_range(19) == 0);
    r = ($urandom_range(99) < readyp);
    mem_ack       = a;
    mem_rdata     = mem_req ? word_of(mem_addr) : $urandom;
    instr_ready   = r;
    branch_valid  = br;
    branch_target = tgt;

    if (q.size() != 0 && r) begin
      b = q.pop_front();
      log_pc.push_back(instr_pc);
      log_word.push_back(instruction);
      log_cyc.push_back(cyc);
      $display("beat cyc=%0d pc=%h word=%h", cyc, instr_pc, instruction);
    end
    if (drain_owed && a) drain_owed = 1'b0;
    if (br) begin
      q.delete();
      exp_pc = {tgt[31:2], 2'b00};
      if (mem_req && !a) drain_owed = 1'b1;
      idle_run = 0;
    end else if (mem_req && a) begin
      q.push_back('{pc: exp_pc, word: word_of(exp_pc)});
      exp_pc = exp_pc + 32'd4;
    end
    req_hold = mem_req && !a && !br;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_pc.delete();
    log_word.delete();
    log_cyc.delete();
  endtask

  initial begin
    logic [31:0] stream_words [4];
    logic [31:0] tgt;
    bit          br;
    int          ackp, readyp;
    stream_words = '{32'h03B0_1001, 32'h03B0_10AA, 32'h03B0_A0BA, 32'h03B0_A0FF};
    cyc = 0;
    clr = 1'b1;
    mem_ack = 1'b0; mem_rdata = 32'h0; branch_valid = 1'b0; branch_target = 32'h0;
    instr_ready = 1'b0;
    model_reset();

    // Reset values, then the first request one cycle after release.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instruction", instruction, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk);
    #1;
    chk("first_req", 32'(mem_req), 32'd1);
    chk("first_addr", mem_addr, 32'h0);
    chk("first_valid", 32'(instr_valid), 32'd0);

    // Streaming with same-cycle acks: one word per cycle in fetch order.
    clear_log();
    repeat (5) step(100, 100, 1'b0, 32'h0);
    chk("stream_count", 32'(log_pc.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < log_pc.size()) begin
        chk("stream_word", log_word[i], stream_words[i]);
        chk("stream_pc", log_pc[i], 32'(i * 4));
        chk("stream_rate", 32'(log_cyc[i]), 32'(log_cyc[0] + i));
      end
    end

    // Wrap-around instance.
    chk("wrap_count", 32'(wrap_log.size()), 32'd2);
    if (wrap_log.size() == 2) begin
      chk("wrap_pc0", wrap_log[0].pc, 32'hFFFF_FFFC);
      chk("wrap_word0", wrap_log[0].word, 32'h0000_0003);
      chk("wrap_pc1", wrap_log[1].pc, 32'h0000_0000);
      chk("wrap_word1", wrap_log[1].word, 32'hFFFF_FFFF);
    end

    // Backpressure: buffer fills to DEPTH, requests stop, head holds.
    repeat (6) step(100, 0, 1'b0, 32'h0);
    chk("bp_mem_req", 32'(mem_req), 32'd0);
    chk("bp_valid", 32'(instr_valid), 32'd1);
    chk("bp_head_pc", instr_pc, 32'h10);
    chk("bp_head_word", instruction, word_of(32'h10));
    clear_log();
    repeat (4) step(100, 100, 1'b0, 32'h0);
    chk("bp_resume_count", 32'(log_pc.size() >= 3), 32'd1);
    for (int i = 0; i < 3; i++) begin
      if (i < log_pc.size()) chk("bp_resume_pc", log_pc[i], 32'h10 + 32'(i * 4));
    end

    // Branch while a request is outstanding.
    for (int i = 0; i < 10 && !mem_req; i++) step(0, 100, 1'b0, 32'h0);
    chk("br_pending", 32'(mem_req), 32'd1);
    step(0, 100, 1'b1, 32'h0000_0103);
    chk("br_flush_valid", 32'(instr_valid), 32'd0);
    chk("br_drain_req", 32'(mem_req), 32'd0);
    step(100, 100, 1'b0, 32'h0);
    chk("br_new_req", 32'(mem_req), 32'd1);
    chk("br_new_addr", mem_addr, 32'h100);
    clear_log();
    repeat (2) step(100, 100, 1'b0, 32'h0);
    chk("br_first_beat", 32'(log_pc.size()), 32'd1);
    if (log_pc.size() != 0) chk("br_first_pc", log_pc[0], 32'h100);

    // Randomised traffic with redirects.
    for (int seg = 0; seg < 60; seg++) begin
      ackp   = $urandom_range(100);
      readyp = $urandom_range(100);
      repeat (50) begin
        br  = ($urandom_range(15) == 0);
        tgt = ($urandom_range(3) == 0) ? {28'hFFF_FFFF, 4'($urandom)} : $urandom;
        step(ackp, readyp, br, tgt);
      end
    end

    // Clear pulse while in WAIT with one buffered word.
    step(100, 100, 1'b1, 32'h200);
    step(0, 100, 1'b0, 32'h0);
    chk("clr_pre_req", 32'(mem_req), 32'd1);
    step(100, 0, 1'b0, 32'h0);
    chk("clr_pre_one_word", 32'(instr_valid && mem_req), 32'd1);
    clr = 1'b1;
    #1;
    chk("clr_mem_req", 32'(mem_req), 32'd0);
    chk("clr_mem_addr", mem_addr, 32'h0);
    chk("clr_valid", 32'(instr_valid), 32'd0);
    chk("clr_instruction", instruction, 32'h0);
    chk("clr_instr_pc", instr_pc, 32'h0);
    @(negedge clk);
    clr = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    branch_valid = 1'b0;
    instr_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_ack_ignored", 32'(instr_valid), 32'd0);
    chk("clr_reissue_req", 32'(mem_req), 32'd1);
    chk("clr_reissue_addr", mem_addr, 32'h0);
    model_reset();
    repeat (40) step(60, 60, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
